// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- pipeline sequencing controller for the IF/ID/EX1/EX2/WB pipe.
// Tracks instructions in flight through EX1, EX2 and WB in shadow registers. It drives
// the enable, bubble and flush strobes of every pipeline register. It also generates the
// EX1 operand forwarding selects and runs the multi-cycle MUL stall counter in EX2.
// Optional feature macro: HAZ_FWD_EN.
//   Defined   : EX2/WB forwarding into EX1. Only a load-use pair stalls ID.
//   Undefined : forwarding selects are tied to 00. ID stalls while any in-flight stage
//               writes one of its used sources.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [3:0]  id_rd,
    input  logic        id_wr,
    input  logic        id_is_load,
    input  logic        id_is_mul,
    input  logic        ex1_redirect,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex1_en,
    output logic        id_ex1_bubble,
    output logic        ex1_ex2_en,
    output logic        ex2_wb_bubble,
    output logic [1:0]  fwd_rs1_sel,
    output logic [1:0]  fwd_rs2_sel,
    output logic [15:0] stall_cnt
);

    // One shadow entry per stage. The source fields only matter for EX1.
    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       wr;
        logic       load;
        logic       mul;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
    } stage_t;

    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

    stage_t      ex1_q, ex1_d;
    stage_t      ex2_q, ex2_d;
    stage_t      wb_q, wb_d;
    stage_t      id_stage;
    logic [3:0]  mul_cnt_q, mul_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mul_busy;
    logic        id_hazard;

    // A stage produces a value for source rs when it is live, writes a register, and that
    // register is not r0.
    function automatic logic src_hit(input stage_t s, input logic [3:0] rs, input logic used);
        return s.valid & s.wr & (s.rd != 4'd0) & (s.rd == rs) & used;
    endfunction

    assign id_stage = '{valid: id_valid, rd: id_rd, wr: id_wr, load: id_is_load,
                        mul: id_is_mul, rs1: id_rs1, rs2: id_rs2,
                        rs1_used: id_rs1_used, rs2_used: id_rs2_used};

    assign mul_busy  = (mul_cnt_q != 4'd0);
    assign stall_cnt = stall_cnt_q;

`ifdef HAZ_FWD_EN
    // Load-use: a load in EX1 returns its data too late for the instruction in ID, even with forwarding.
    always_comb begin
        id_hazard = id_valid & ex1_q.load &
                    (src_hit(ex1_q, id_rs1, id_rs1_used) | src_hit(ex1_q, id_rs2, id_rs2_used));
    end

    // EX2 beats WB because it is younger. A load in EX2 has no data yet, so it is not forwarded.
    function automatic logic [1:0] fwd_pick(input stage_t e2, input stage_t wb,
                                            input logic [3:0] rs, input logic used);
        if (src_hit(e2, rs, used) && !e2.load)
            return 2'b01;
        else if (src_hit(wb, rs, used))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // EX1 operand selects are re-evaluated every cycle, including while EX1 is frozen.
    always_comb begin
        fwd_rs1_sel = 2'b00;
        fwd_rs2_sel = 2'b00;
        if (!rst) begin
            fwd_rs1_sel = fwd_pick(ex2_q, wb_q, ex1_q.rs1, ex1_q.valid & ex1_q.rs1_used);
            fwd_rs2_sel = fwd_pick(ex2_q, wb_q, ex1_q.rs2, ex1_q.valid & ex1_q.rs2_used);
        end
    end

    logic unused_shadow;
    assign unused_shadow = ^{ex2_q.mul, ex2_q.rs1, ex2_q.rs2, ex2_q.rs1_used, ex2_q.rs2_used,
                             wb_q.load, wb_q.mul, wb_q.rs1, wb_q.rs2, wb_q.rs1_used,
                             wb_q.rs2_used};
`else
    // Without forwarding a consumer waits until every producer of its sources has left WB.
    // The regfile has no write-through.
    always_comb begin
        id_hazard = id_valid &
                    (src_hit(ex1_q, id_rs1, id_rs1_used) | src_hit(ex1_q, id_rs2, id_rs2_used) |
                     src_hit(ex2_q, id_rs1, id_rs1_used) | src_hit(ex2_q, id_rs2, id_rs2_used) |
                     src_hit(wb_q,  id_rs1, id_rs1_used) | src_hit(wb_q,  id_rs2, id_rs2_used));
    end

    assign fwd_rs1_sel = 2'b00;
    assign fwd_rs2_sel = 2'b00;

    logic unused_shadow;
    assign unused_shadow = ^{ex1_q.load, ex1_q.rs1, ex1_q.rs2, ex1_q.rs1_used, ex1_q.rs2_used,
                             ex2_q.load, ex2_q.mul, ex2_q.rs1, ex2_q.rs2, ex2_q.rs1_used,
                             ex2_q.rs2_used, wb_q.load, wb_q.mul, wb_q.rs1, wb_q.rs2,
                             wb_q.rs1_used, wb_q.rs2_used};
`endif

    // Strobe priority is MUL hold, then redirect, then the ID hazard stall. Everything runs while reset is asserted.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex1_en     = 1'b1;
        id_ex1_bubble = 1'b0;
        ex1_ex2_en    = 1'b1;
        ex2_wb_bubble = 1'b0;
        if (!rst) begin
            if (mul_busy) begin
                // The MUL sits in EX2. Everything behind it freezes, so a redirect
                // resolved in the held EX1 waits until EX1 moves again.
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex1_en     = 1'b0;
                ex1_ex2_en    = 1'b0;
                ex2_wb_bubble = 1'b1;
            end else if (ex1_redirect) begin
                if_id_flush   = 1'b1;
                id_ex1_bubble = 1'b1;
            end else if (id_hazard) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex1_bubble = 1'b1;
            end
        end
    end

    // Shadows advance exactly as the real pipeline registers do. The MUL counter and the stall counter update here too.
    always_comb begin
        ex1_d       = ex1_q;
        ex2_d       = ex2_q;
        wb_d        = wb_q;
        mul_cnt_d   = mul_cnt_q;
        stall_cnt_d = stall_cnt_q;

        wb_d = ex2_wb_bubble ? '0 : ex2_q;
        if (ex1_ex2_en)
            ex2_d = ex1_q;
        if (id_ex1_en)
            ex1_d = id_ex1_bubble ? '0 : id_stage;

        if (ex1_ex2_en && ex1_q.valid && ex1_q.mul)
            mul_cnt_d = MUL_CNT_INIT;
        else if (mul_busy)
            mul_cnt_d = mul_cnt_q - 4'd1;

        // A redirect costs a cycle but is not counted as a stall. The count saturates instead of wrapping.
        if ((mul_busy || id_hazard) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // State registers. Reset empties the shadows and aborts any MUL count in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex1_q       <= '0;
            ex2_q       <= '0;
            wb_q        <= '0;
            mul_cnt_q   <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            ex1_q       <= ex1_d;
            ex2_q       <= ex2_d;
            wb_q        <= wb_d;
            mul_cnt_q   <= mul_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl using directed vectors.
// The stimulus process drives one ID/redirect vector per cycle.
// For each vector it pushes the hand-computed strobes, selects and stall count onto a queue.
// A monitor pops one expectation per cycle on the falling edge and compares it with the DUT.
// Expectations follow the build: HAZ_FWD_EN defined or not.
module tb_pipe_hazard_ctrl;

    // Strobe vector: {pc_en, if_id_en, if_id_flush, id_ex1_en, id_ex1_bubble, ex1_ex2_en, ex2_wb_bubble}
    localparam logic [6:0] NRM = 7'b1101010;
    localparam logic [6:0] STL = 7'b0001110;
    localparam logic [6:0] MUL = 7'b0000001;
    localparam logic [6:0] RDR = 7'b1111110;

    typedef struct {
        int          tag;
        logic [6:0]  strb;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [15:0] sc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_wr, id_is_load, id_is_mul;
    logic        ex1_redirect;
    logic        pc_en, if_id_en, if_id_flush, id_ex1_en, id_ex1_bubble;
    logic        ex1_ex2_en, ex2_wb_bubble;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic [15:0] stall_cnt;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   tag    = 0;
    int   s      = 0;

    pipe_hazard_ctrl #(.MUL_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
        .ex1_redirect(ex1_redirect),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex1_en(id_ex1_en), .id_ex1_bubble(id_ex1_bubble),
        .ex1_ex2_en(ex1_ex2_en), .ex2_wb_bubble(ex2_wb_bubble),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one vector just after the rising edge and queue the expected response for this cycle.
    task automatic issue(input logic r, input logic v,
                         input logic [3:0] s1, input logic u1, input logic [3:0] s2, input logic u2,
                         input logic [3:0] d, input logic w, input logic ld, input logic ml,
                         input logic redir,
                         input logic [6:0] strb, input logic [1:0] f1, input logic [1:0] f2,
                         input int sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v;
        id_rs1 = s1; id_rs1_used = u1; id_rs2 = s2; id_rs2_used = u2;
        id_rd = d; id_wr = w; id_is_load = ld; id_is_mul = ml; ex1_redirect = redir;
        e.tag = tag; e.strb = strb; e.f1 = f1; e.f2 = f2; e.sc = 16'(sc);
        exp_q.push_back(e);
        tag++;
    endtask

    task automatic idle(input logic [6:0] strb, input logic [1:0] f1, input logic [1:0] f2,
                        input int sc);
        issue(0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, strb, f1, f2, sc);
    endtask

    // Monitor: one comparison per queued expectation, taken mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [6:0] got;
            e = exp_q.pop_front();
            got = {pc_en, if_id_en, if_id_flush, id_ex1_en, id_ex1_bubble, ex1_ex2_en, ex2_wb_bubble};
            n_vec++;
            if (got !== e.strb || fwd_rs1_sel !== e.f1 || fwd_rs2_sel !== e.f2 || stall_cnt !== e.sc) begin
                n_fail++;
                $display("FAIL vec%0d: got strb=%b fwd1=%b fwd2=%b stall=%0d, expected strb=%b fwd1=%b fwd2=%b stall=%0d",
                         e.tag, got, fwd_rs1_sel, fwd_rs2_sel, stall_cnt, e.strb, e.f1, e.f2, e.sc);
            end else begin
                $display("vec%0d ok: strb=%b fwd1=%b fwd2=%b stall=%0d",
                         e.tag, got, fwd_rs1_sel, fwd_rs2_sel, stall_cnt);
            end
        end
    end

    initial begin
        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_wr = 0; id_is_load = 0; id_is_mul = 0; ex1_redirect = 0;

        // Reset held with a redirect and a live ID: everything enabled, no flush, fwd 00.
        issue(1, 1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 1, NRM, 2'b00, 2'b00, 0);
        issue(1, 1, 4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 0, 1, NRM, 2'b00, 2'b00, 0);

        // ADD r2 then ADD r4 = r2 + r3.
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 0, 0, 0, NRM, 2'b00, 2'b00, 0);
`ifdef HAZ_FWD_EN
        issue(0, 1, 4'd2, 1, 4'd3, 1, 4'd4, 1, 0, 0, 0, NRM, 2'b00, 2'b00, 0);
        idle(NRM, 2'b01, 2'b00, 0);
`else
        issue(0, 1, 4'd2, 1, 4'd3, 1, 4'd4, 1, 0, 0, 0, STL, 2'b00, 2'b00, 0);
        issue(0, 1, 4'd2, 1, 4'd3, 1, 4'd4, 1, 0, 0, 0, STL, 2'b00, 2'b00, 1);
        issue(0, 1, 4'd2, 1, 4'd3, 1, 4'd4, 1, 0, 0, 0, STL, 2'b00, 2'b00, 2);
        issue(0, 1, 4'd2, 1, 4'd3, 1, 4'd4, 1, 0, 0, 0, NRM, 2'b00, 2'b00, 3);
        idle(NRM, 2'b00, 2'b00, 3);
        s = 3;
`endif
        repeat (3) idle(NRM, 2'b00, 2'b00, s);

        // Producer writes r0, consumer reads r0 on both ports: no stall, no forwarding.
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd0, 1, 0, 0, 0, NRM, 2'b00, 2'b00, s);
        issue(0, 1, 4'd0, 1, 4'd0, 1, 4'd6, 1, 0, 0, 0, NRM, 2'b00, 2'b00, s);
        idle(NRM, 2'b00, 2'b00, s);

        // Redirect with no stall: flush IF/ID and bubble ID/EX1.
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd7, 1, 0, 0, 1, RDR, 2'b00, 2'b00, s);
        idle(NRM, 2'b00, 2'b00, s);

        // MUL r8 enters EX2 for two stall cycles. A redirect held in EX1 only flushes afterwards.
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd8, 1, 0, 1, 0, NRM, 2'b00, 2'b00, s);
        issue(0, 1, 4'd10, 1, 4'd0, 0, 4'd9, 1, 0, 0, 0, NRM, 2'b00, 2'b00, s);
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd11, 1, 0, 0, 1, MUL, 2'b00, 2'b00, s);
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd11, 1, 0, 0, 1, MUL, 2'b00, 2'b00, s + 1);
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd11, 1, 0, 0, 1, RDR, 2'b00, 2'b00, s + 2);
        s = s + 2;
        idle(NRM, 2'b00, 2'b00, s);

        // LOAD r5, then a consumer reading r5 through rs2.
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd5, 1, 1, 0, 0, NRM, 2'b00, 2'b00, s);
`ifdef HAZ_FWD_EN
        issue(0, 1, 4'd1, 1, 4'd5, 1, 4'd12, 1, 0, 0, 0, STL, 2'b00, 2'b00, s);
        issue(0, 1, 4'd1, 1, 4'd5, 1, 4'd12, 1, 0, 0, 0, NRM, 2'b00, 2'b00, s + 1);
        s = s + 1;
        idle(NRM, 2'b00, 2'b10, s);

        // Two ADD r3 in a row, then a consumer of r3 with rs2=r3 unused: EX2 wins, rs2 stays 00.
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd3, 1, 0, 0, 0, NRM, 2'b00, 2'b00, s);
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd3, 1, 0, 0, 0, NRM, 2'b00, 2'b00, s);
        issue(0, 1, 4'd3, 1, 4'd3, 0, 4'd13, 1, 0, 0, 0, NRM, 2'b00, 2'b00, s);
        idle(NRM, 2'b01, 2'b00, s);
`else
        issue(0, 1, 4'd1, 1, 4'd5, 1, 4'd12, 1, 0, 0, 0, STL, 2'b00, 2'b00, s);
        issue(0, 1, 4'd1, 1, 4'd5, 1, 4'd12, 1, 0, 0, 0, STL, 2'b00, 2'b00, s + 1);
        issue(0, 1, 4'd1, 1, 4'd5, 1, 4'd12, 1, 0, 0, 0, STL, 2'b00, 2'b00, s + 2);
        issue(0, 1, 4'd1, 1, 4'd5, 1, 4'd12, 1, 0, 0, 0, NRM, 2'b00, 2'b00, s + 3);
        s = s + 3;
        idle(NRM, 2'b00, 2'b00, s);
`endif
        repeat (3) idle(NRM, 2'b00, 2'b00, s);

        // Reset pulse while a MUL is counting: the hold and the stall count clear at once.
        issue(0, 1, 4'd1, 1, 4'd0, 0, 4'd14, 1, 0, 1, 0, NRM, 2'b00, 2'b00, s);
        idle(NRM, 2'b00, 2'b00, s);
        idle(MUL, 2'b00, 2'b00, s);
        issue(1, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 0);
        s = 0;
        idle(NRM, 2'b00, 2'b00, s);
        idle(NRM, 2'b00, 2'b00, s);

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 16-bit CPU's IF/ID/EX1/EX2/WB pipe. It tracks destination registers in flight through EX1, EX2 and WB, and drives the enable/bubble/flush strobes of every pipeline register (including the EX1→EX2 register). It also generates forwarding selects for the EX1 operands and runs the multi-cycle multiplier stall counter in EX2. Loads return data at the end of EX2; branches resolve in EX1.

## Interface
- MUL_LAT, 3, cycles a MUL occupies EX2 (legal 1..15)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  4 each  ID source registers
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- id_rd  in  4  ID destination
- id_wr  in  1  ID writes id_rd
- id_is_load, id_is_mul  in  1 each  ID instruction class
- ex1_redirect  in  1  branch taken / jump resolved in EX1
- pc_en, if_id_en  out  1 each  PC and IF/ID register load enables
- if_id_flush  out  1  IF/ID register loads NOP
- id_ex1_en, id_ex1_bubble  out  1 each  ID/EX1 enable; load NOP instead of ID
- ex1_ex2_en  out  1  EX1/EX2 register enable
- ex2_wb_bubble  out  1  EX2/WB register loads NOP
- fwd_rs1_sel, fwd_rs2_sel  out  2 each  EX1 operand source: 00 regfile, 01 EX2 alu_out, 10 WB result
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Shadow stages EX1, EX2 and WB each hold {valid, rd, wr, load, mul}, plus rs1/rs2/used for EX1. All valid bits clear on reset.
- r0 is hardwired zero: rd==0 never matches, never forwards, never stalls.
- mul_busy = (mul_cnt != 0). Entering EX2 with mul loads mul_cnt = MUL_LAT-1; the counter decrements each cycle while nonzero. MUL_LAT=1 never stalls.
- load_use = id_valid & ex1.valid & ex1.load & ex1.wr & ex1.rd≠0 & (rs1 match & rs1_used | rs2 match & rs2_used).
- Priority:
  - mul_busy: pc_en = if_id_en = id_ex1_en = ex1_ex2_en = 0; ex2_wb_bubble = 1. ex1_redirect is ignored while EX1 is held.
  - Else ex1_redirect: if_id_flush = 1, id_ex1_bubble = 1, all enables 1.
  - Else load_use: pc_en = if_id_en = 0, id_ex1_en = 1, id_ex1_bubble = 1.
  - Else all enables 1, bubbles/flush 0.
- Shadow advance mirrors the strobes: a bubble clears the next stage's valid, a hold keeps contents. A stage with valid=0 never matches.
- Forwarding (EX1 operands): EX2 match with EX2 not a load → 01; else WB match → 10; else 00. EX2 has priority over WB. The select is 00 when the operand is unused.
- stall_cnt increments on any cycle with mul_busy or load_use (redirect is not a stall) and saturates at 0xFFFF.

## Timing
- Outputs are combinational from shadow state and ID inputs. State updates on posedge clk.
- Reset (async): shadows invalid, mul_cnt=0, stall_cnt=0. While rst is asserted, all enables = 1, bubbles/flush = 0, fwd = 00.
- Load-use costs exactly 1 cycle. The consumer enters EX1 with the load in WB and fwd=10.
- MUL costs MUL_LAT-1 stall cycles. The instruction behind it in EX1 stays frozen and its fwd selects are re-evaluated every cycle.
- Simultaneous mul_busy and load_use: only the mul stall applies. load_use is re-evaluated when EX1 advances.
- Reset mid-MUL aborts the count immediately.

## Configuration
- HAZ_FWD_EN defined: forwarding as above.
- Undefined: fwd selects are tied to 00. The load_use term is replaced by raw_hazard, which stalls ID (same strobes as load_use) while any valid EX1, EX2 or WB stage writes a used source. The regfile has no write-through, so a consumer waits until its producer leaves WB. stall_cnt counts these stalls.

## Test plan
- ADD r3 in EX2, consumer in EX1 reading r3 → fwd_rs1_sel=01. With r3 also in WB, the select stays 01.
- LOAD r5 in EX1, ID reads r5 as rs2 → one cycle with pc_en=0 and id_ex1_bubble=1. Next cycle: consumer in EX1, fwd_rs2_sel=10, stall_cnt=1.
- MUL enters EX2 with MUL_LAT=3 → ex1_ex2_en=0 and ex2_wb_bubble=1 for 2 cycles, then resume. stall_cnt=2.
- ex1_redirect with no stall → if_id_flush=1 and id_ex1_bubble=1 in that cycle. Redirect during mul_busy → no flush until EX1 advances.
- Producer rd=r0 followed by consumer reading r0 → fwd=00, no stall. rst pulse mid-MUL → mul_busy=0 and stall_cnt=0 immediately.
- HAZ_FWD_EN undefined: ADD r2 then dependent ADD → 3 stall cycles, fwd always 00.
